// File: rtl/stall_pkg.sv
// Shared definitions for the coprocessor stall controller: FSM encoding, the latency value that means wait for ack, and default channels for the existing AES/IM opcodes.
// Latency: n/a (package only).
// Backpressure: n/a. Using the opcode channel assignments below requires NCH >= CH_MIN_NCH.
package stall_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Latency field width the opcode map was laid out for; all-ones means "no timed release, ack only".
    localparam int               LAT_W_DFLT = 4;
    localparam logic [LAT_W_DFLT-1:0] LAT_INF = '1;

    // Default request-channel index per existing custom opcode enable.
    localparam int EN_ADDROUND  = 0;
    localparam int EN_SUBBYTES  = 1;
    localparam int EN_SHIFTROWS = 2;
    localparam int EN_MIXCOL    = 3;
    localparam int EN_INVSUB    = 4;
    localparam int EN_INVSHIFT  = 5;
    localparam int EN_INVMIX    = 6;
    localparam int EN_KEYEXP    = 7;
    localparam int EN_AESENC    = 8;
    localparam int EN_AESDEC    = 9;
    localparam int IMCADD       = 10;
    localparam int IMCSUB       = 11;
    localparam int IMCMUL       = 12;
    localparam int IMCMAC       = 13;
    localparam int IMCXOR       = 14;
    localparam int IMCAND       = 15;
    localparam int IMCOR        = 16;
    localparam int IMCROT       = 17;
    localparam int IMCSHL       = 18;
    localparam int IMCSHR       = 19;
    localparam int IMCSL        = 20;

    localparam int CH_MIN_NCH   = IMCSL + 1;

endpackage

// File: rtl/stall_prio_enc.sv
// Lowest-index priority encoder: vld when any request bit is set, idx of the lowest set bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the input vector directly.
// Ports: req (N-bit request vector) -> vld, idx (IW bits, 0 when no request).
module stall_prio_enc #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the last hit, the lowest set bit, wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/coproc_stall_ctrl.sv
// Stall/handshake controller for custom-instruction coprocessors: one lowest-index channel at a time is held for its programmed latency or until ack.
// Latency: lat=L gives L halt cycles starting in the accept cycle; done/halt are combinational from req, ack, state and cnt.
// Backpressure: losing and non-active requesters see done=0 (stall) until they win arbitration in a later IDLE cycle.
// Ports: clk, res (async active-low) | req, lat_cfg (LAT_W per channel), ack in | done, halt, busy, act_ch, err out.
// Optional feature: define STALL_WDOG_EN to build the watchdog (forced release after TIMEOUT cycles, sticky err).
module coproc_stall_ctrl
    import stall_pkg::*;
#(
    parameter int NCH     = 16,
    parameter int LAT_W   = 4,
    parameter int TIMEOUT = 255,
    localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*LAT_W-1:0] lat_cfg,
    input  logic [NCH-1:0]       ack,
    output logic [NCH-1:0]       done,
    output logic                 halt,
    output logic                 busy,
    output logic [IW-1:0]        act_ch,
    output logic                 err
);

    // Width-matched all-ones latency (same meaning as LAT_INF at the default width).
    localparam logic [LAT_W-1:0] LAT_INF_W = '1;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    act_q, act_d;
    logic             inf_q, inf_d;

    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [LAT_W-1:0] win_lat;
    logic             act_req;
    logic             act_ack;
    logic             wd_fire;

    stall_prio_enc #(
        .N  (NCH),
        .IW (IW)
    ) u_prio (
        .req (req),
        .vld (win_vld),
        .idx (win_idx)
    );

    assign win_lat = lat_cfg[win_idx * LAT_W +: LAT_W];
    assign act_req = req[act_q];
    assign act_ack = ack[act_q];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            act_q   <= '0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            inf_q   <= inf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        inf_d   = inf_q;
        // Idle channels never stall; every requester stalls unless released below.
        done    = ~req;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    if (win_lat == '0) begin
                        done[win_idx] = 1'b1;
                    end else begin
                        // The accept cycle itself is the first stall cycle, hence lat-1.
                        act_d   = win_idx;
                        cnt_d   = win_lat - LAT_W'(1);
                        inf_d   = (win_lat == LAT_INF_W);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!act_req) begin
                    // Core flushed the instruction: drop it without a done pulse.
                    state_d = ST_IDLE;
                end else if ((!inf_q && cnt_q == '0) || act_ack || wd_fire) begin
                    done[act_q] = 1'b1;
                    state_d     = ST_IDLE;
                end else if (!inf_q && cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign halt   = ~&done;
    assign busy   = (state_q == ST_WAIT);
    assign act_ch = act_q;

`ifdef STALL_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    // wdog counts stall cycles including the accept cycle, so it equals TIMEOUT in stall cycle TIMEOUT.
    assign wd_fire = (state_q == ST_WAIT) && act_req && (wdog_q == WD_W'(TIMEOUT));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_WAIT) begin
                wdog_q <= WD_W'(1);
            end else if (state_q == ST_WAIT && wdog_q != WD_W'(TIMEOUT)) begin
                wdog_q <= wdog_q + WD_W'(1);
            end
            if (wd_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wd_fire        = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_stall_ctrl.sv
// Self-checking bench for coproc_stall_ctrl: directed scenarios with literal expectations plus randomized core/accelerator traffic.
// Latency: n/a (testbench).
// Backpressure: the modelled core drops a request the cycle after it sees done, and occasionally flushes one.
`timescale 1ns/1ps
module tb_coproc_stall_ctrl;

    localparam int NCH   = 16;
    localparam int LAT_W = 4;
    localparam int IW    = 4;
    localparam int TMO   = 10;
    localparam int LINF  = 15;
`ifdef STALL_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 res;
    logic [NCH-1:0]       req;
    logic [NCH*LAT_W-1:0] lat_cfg;
    logic [NCH-1:0]       ack;
    logic [NCH-1:0]       done;
    logic                 halt;
    logic                 busy;
    logic [IW-1:0]        act_ch;
    logic                 err;

    always #5 clk = ~clk;

    coproc_stall_ctrl #(
        .NCH     (NCH),
        .LAT_W   (LAT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .lat_cfg (lat_cfg),
        .ack     (ack),
        .done    (done),
        .halt    (halt),
        .busy    (busy),
        .act_ch  (act_ch),
        .err     (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return int'(lat_cfg[i*LAT_W +: LAT_W]);
    endfunction

    task automatic set_lat(input int ch, input int v);
        lat_cfg[ch*LAT_W +: LAT_W] = LAT_W'(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: which channel is in flight, its sampled latency, and
    // how many cycles have passed since it was accepted (accept cycle = 0).
    int             m_act = -1;
    int             m_lat = 0;
    int             m_t   = 0;
    bit             m_err = 1'b0;
    logic [NCH-1:0] exp_done = '1;

    always @(negedge clk) begin
        int w;
        bit rel;
        bit forced;
        if (!res) begin
            m_act = -1;
            m_err = 1'b0;
        end
        exp_done = ~req;
        w = -1;
        for (int i = NCH - 1; i >= 0; i--) if (req[i]) w = i;
        rel    = 1'b0;
        forced = 1'b0;
        if (m_act < 0) begin
            if (w >= 0 && lat_of(w) == 0) exp_done[w] = 1'b1;
        end else begin
            forced = WD && (m_t >= TMO);
            rel = req[m_act] && ((m_lat != LINF && m_t >= m_lat) || ack[m_act] || forced);
            if (rel) exp_done[m_act] = 1'b1;
        end
        chk("done", done, exp_done);
        chk("halt", halt, !(&exp_done));
        chk("busy", busy, m_act >= 0);
        chk("err", err, m_err);
        if (m_act >= 0) chk("act_ch", act_ch, m_act);
        if (res) begin
            if (m_act < 0) begin
                if (w >= 0 && lat_of(w) != 0) begin
                    m_act = w;
                    m_lat = lat_of(w);
                    m_t   = 1;
                end
            end else if (!req[m_act] || rel) begin
                if (rel && forced) m_err = 1'b1;
                m_act = -1;
            end else begin
                m_t++;
            end
        end
    end

    initial begin
        int ch;
        int r;
        res     = 1'b0;
        req     = '0;
        ack     = '0;
        lat_cfg = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_halt", halt, 0);
        chk("rst_err", err, 0);
        chk("rst_act", act_ch, 0);
        chk("rst_done", done, 16'hFFFF);
        cyc(); res = 1'b1;

        // lat=1: one stall cycle, done in cycle 1, idle again in cycle 2.
        cyc(); set_lat(3, 1); req = 16'h0008; #2;
        chk("A0_halt", halt, 1); chk("A0_done3", done[3], 0);
        cyc(); #2;
        chk("A1_halt", halt, 0); chk("A1_done3", done[3], 1);
        chk("A1_busy", busy, 1); chk("A1_act", act_ch, 3);
        cyc(); req = '0; #2;
        chk("A2_busy", busy, 0);

        // lat=0: never stalls.
        cyc(); set_lat(5, 0); req = 16'h0020; #2;
        chk("B0_done5", done[5], 1); chk("B0_halt", halt, 0); chk("B0_busy", busy, 0);
        cyc(); #2;
        chk("B1_busy", busy, 0);
        cyc(); req = '0;

        // lat=5 cut short by ack in cycle 2.
        cyc(); set_lat(2, 5); req = 16'h0004; #2;
        chk("C0_halt", halt, 1);
        cyc(); #2;
        chk("C1_halt", halt, 1); chk("C1_busy", busy, 1);
        cyc(); ack = 16'h0004; #2;
        chk("C2_done2", done[2], 1); chk("C2_halt", halt, 0);
        cyc(); req = '0; ack = '0; #2;
        chk("C3_busy", busy, 0);

        // Two simultaneous lat=2 requests: 1 retires cycle 2, 4 accepted cycle 3, retires cycle 5.
        cyc(); set_lat(1, 2); set_lat(4, 2); req = 16'h0012; #2;
        chk("D0_done4", done[4], 0); chk("D0_done1", done[1], 0);
        cyc(); #2;
        chk("D1_act", act_ch, 1);
        cyc(); #2;
        chk("D2_done1", done[1], 1); chk("D2_done4", done[4], 0);
        cyc(); req = 16'h0010; #2;
        chk("D3_busy", busy, 0); chk("D3_halt", halt, 1);
        cyc(); #2;
        chk("D4_busy", busy, 1); chk("D4_act", act_ch, 4);
        cyc(); #2;
        chk("D5_done4", done[4], 1); chk("D5_halt", halt, 0);
        cyc(); req = '0;

        // Reset mid-WAIT, then a fresh accept with the full latency; a lat change in flight is ignored.
        cyc(); set_lat(6, 7); req = 16'h0040;
        cyc();
        cyc();
        cyc(); res = 1'b0; #2;
        chk("E_busy", busy, 0); chk("E_halt", halt, 1);
        chk("E_done6", done[6], 0); chk("E_act", act_ch, 0);
        cyc(); res = 1'b1; #2;
        chk("E0_halt", halt, 1);
        cyc(); set_lat(6, 1);
        repeat (5) cyc();
        #2;
        chk("E6_done6", done[6], 0); chk("E6_halt", halt, 1);
        cyc(); #2;
        chk("E7_done6", done[6], 1); chk("E7_halt", halt, 0);
        cyc(); req = '0;

        // All-ones latency with no ack.
        cyc(); set_lat(0, LINF); req = 16'h0001;
        repeat (9) cyc();
        #2;
        chk("F9_halt", halt, 1);
`ifdef STALL_WDOG_EN
        cyc(); #2;
        chk("F10_done0", done[0], 1); chk("F10_err", err, 0);
        cyc(); req = '0; #2;
        chk("F11_err", err, 1); chk("F11_busy", busy, 0);
        repeat (3) cyc();
        #2;
        chk("F14_err", err, 1);
        cyc(); res = 1'b0; #2;
        chk("F_rst_err", err, 0);
        cyc(); res = 1'b1;
`else
        cyc(); #2;
        chk("F10_done0", done[0], 0); chk("F10_err", err, 0);
        cyc(); ack = 16'h0001; #2;
        chk("F11_done0", done[0], 1);
        cyc(); req = '0; ack = '0;
`endif

        // Randomized traffic: requests retire the cycle after done, occasional flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            res = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < NCH; i++) begin
                if (req[i]) begin
                    if (exp_done[i] || $urandom_range(0, 99) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    req[i] = 1'b1;
                end
            end
            ch = $urandom_range(0, NCH - 1);
            r  = $urandom_range(0, 9);
            set_lat(ch, (r == 0) ? 0 : (r == 1) ? LINF : $urandom_range(1, 14));
            ack = NCH'($urandom & $urandom & $urandom);
        end
        cyc(); res = 1'b1; req = '0; ack = '0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
